// File: rtl/fx2_pkt_loopback.sv
// FX2 slave-FIFO loop-back: buffers PKT_BYTES from EP2 in RAM, returns them to EP6, PKTEND on short packets.
// Optional build macro FX2LB_CHECKSUM_EN appends a mod-256 sum byte after the payload.
module fx2_pkt_loopback #(
  parameter int         ADDR_W     = 9,
  parameter int         PKT_BYTES  = 512,
  parameter int         USB_MPS    = 512,
  parameter logic [1:0] RX_FIFOADR = 2'b00,
  parameter logic [1:0] TX_FIFOADR = 2'b10
) (
  input  logic       FIFO_CLK,
  input  logic       reset_n,
  input  logic [7:0] fifo_datain,
  output logic [7:0] fifo_dataout,
  output logic       fifo_dataout_oe,
  output logic       fifo_datain_oe,
  output logic       fifo_rd,
  output logic       fifo_wr,
  output logic       fifo_pktend,
  output logic [1:0] fifo_fifoadr,
  input  logic       rx_avail,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] pkt_count
);

`ifdef FX2LB_CHECKSUM_EN
  localparam int TX_LEN = PKT_BYTES + 1;
`else
  localparam int TX_LEN = PKT_BYTES;
`endif
  localparam bit                NEED_PKTEND = (TX_LEN % USB_MPS) != 0;
  localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(PKT_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_TURN, S_TX, S_PKTEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        pkt_count_q, pkt_count_d;
  logic [7:0]        ram_q;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
`ifdef FX2LB_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              cks_q, cks_d;
`endif

  always_ff @(posedge FIFO_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      ram_q       <= '0;
`ifdef FX2LB_CHECKSUM_EN
      sum_q       <= '0;
      cks_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      ram_q       <= mem[rd_addr];
`ifdef FX2LB_CHECKSUM_EN
      sum_q       <= sum_d;
      cks_q       <= cks_d;
`endif
    end
  end

  // Payload storage has no reset; contents are only read after being written.
  always_ff @(posedge FIFO_CLK) begin
    if (fifo_rd) mem[wr_ptr_q] <= fifo_datain;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    rd_addr     = rd_ptr_q;
`ifdef FX2LB_CHECKSUM_EN
    sum_d       = sum_q;
    cks_d       = cks_q;
`endif
    case (state_q)
      S_IDLE: if (rx_avail) state_d = S_RX;
      S_RX: begin
        if (fifo_rd) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef FX2LB_CHECKSUM_EN
          sum_d    = sum_q + fifo_datain;
`endif
          if (wr_ptr_q == LAST_PTR) state_d = S_TURN;
        end
      end
      S_TURN: begin
        rd_addr = '0;
        state_d = S_TX;
      end
      S_TX: begin
        // Prefetch the next address on acceptance; a stall re-reads the same one.
        if (fifo_wr) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          rd_addr  = rd_ptr_d;
`ifdef FX2LB_CHECKSUM_EN
          if (cks_q) state_d = NEED_PKTEND ? S_PKTEND : S_DONE;
          else if (rd_ptr_q == LAST_PTR) cks_d = 1'b1;
`else
          if (rd_ptr_q == LAST_PTR) state_d = NEED_PKTEND ? S_PKTEND : S_DONE;
`endif
        end
      end
      S_PKTEND: if (tx_ready) state_d = S_DONE;
      S_DONE: begin
        pkt_count_d = pkt_count_q + 8'd1;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        rd_addr     = '0;
`ifdef FX2LB_CHECKSUM_EN
        sum_d       = '0;
        cks_d       = 1'b0;
`endif
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd         = (state_q == S_RX) && rx_avail;
    fifo_wr         = (state_q == S_TX) && tx_ready;
    fifo_dataout_oe = fifo_wr;
    fifo_pktend     = (state_q == S_PKTEND) && tx_ready;
    busy            = (state_q != S_IDLE);
    pkt_count       = pkt_count_q;
    fifo_datain_oe  = 1'b1;
    fifo_fifoadr    = RX_FIFOADR;
    if (state_q == S_TURN || state_q == S_TX || state_q == S_PKTEND) begin
      fifo_datain_oe = 1'b0;
      fifo_fifoadr   = TX_FIFOADR;
    end
    fifo_dataout = ram_q;
`ifdef FX2LB_CHECKSUM_EN
    if (cks_q) fifo_dataout = sum_q;
`endif
  end

endmodule
